// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves HPS upload byte reads from core work RAM while the core CPU is paused.
// Optional IOCTL_UPLOAD_CHECKSUM_EN: a read of LAST_ADDR+1 returns the negated byte sum of the session.
module ioctl_upload_reader #(
    parameter logic [7:0]    UPLOAD_INDEX = 8'd2,
    parameter int            AW           = 11,
    parameter logic [AW-1:0] LAST_ADDR    = 11'h7FF,
    parameter logic [7:0]    TIMEOUT      = 8'd255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_dout,
    input  logic          ram_valid
);
    typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, HOLD} state_t;
    localparam logic [24:0] LAST_A = 25'(LAST_ADDR);

    state_t        state_q, state_d;
    logic [7:0]    din_q, din_d, cnt_q, cnt_d, oor_byte;
    logic [AW-1:0] addr_q, addr_d;
    logic          ram_rd_q, ram_rd_d, pend_q, pend_d;
    logic          sess, oor, fetch_live, capture, tmo;

    assign sess = ioctl_upload && ioctl_index == UPLOAD_INDEX;
    assign oor = ioctl_addr > LAST_A;
    assign fetch_live = sess && pause_ack && state_q == FETCH;
    // ram_valid in the request cycle itself cannot belong to this request (latency >= 1)
    assign capture = fetch_live && ram_valid && !ram_rd_q;
    assign tmo = fetch_live && !capture && cnt_q == TIMEOUT - 8'd1;

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else sum_q <= state_q == IDLE ? 8'd0 : capture ? sum_q + ram_dout : sum_q;
    end
    assign oor_byte = ioctl_addr == LAST_A + 25'd1 ? 8'd0 - sum_q : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            din_q    <= '0;
            addr_q   <= '0;
            ram_rd_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            addr_q   <= addr_d;
            ram_rd_q <= ram_rd_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!sess) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    state_d = PAUSE;
                PAUSE:   state_d = !pause_ack ? PAUSE : pend_q ? FETCH : READY;
                READY:   state_d = !pause_ack ? PAUSE : (ioctl_rd && !oor) ? FETCH : READY;
                FETCH:   state_d = !pause_ack ? PAUSE : (capture || tmo) ? HOLD : FETCH;
                HOLD:    state_d = pause_ack ? READY : PAUSE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A read interrupted by pause loss stays pending and is re-issued on re-ack
    always_comb begin
        din_d    = din_q;
        addr_d   = addr_q;
        ram_rd_d = 1'b0;
        pend_d   = sess && state_q != IDLE && pend_q;
        cnt_d    = '0;
        if (sess && state_q == READY && ioctl_rd) begin
            din_d    = oor ? oor_byte : din_q;
            addr_d   = oor ? addr_q : ioctl_addr[AW-1:0];
            ram_rd_d = !oor && pause_ack;
            pend_d   = !oor && !pause_ack;
        end
        if (sess && state_q == PAUSE && pause_ack && pend_q) begin
            ram_rd_d = 1'b1;
            pend_d   = 1'b0;
        end
        if (sess && state_q == FETCH) begin
            din_d  = capture ? ram_dout : tmo ? 8'h00 : din_q;
            pend_d = !pause_ack;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_comb begin
        pause_req  = state_q != IDLE;
        ioctl_wait = state_q == PAUSE || state_q == FETCH || state_q == HOLD;
    end

    assign ioctl_din = din_q;
    assign ram_addr  = addr_q;
    assign ram_rd    = ram_rd_q;
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: randomized scoreboard bench with a latency-modelled RAM responder.
module tb_ioctl_upload_reader;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    logic        clk_sys = 1'b0;
    logic        reset_n, ioctl_upload, ioctl_rd, pause_ack, ram_valid;
    logic [7:0]  ioctl_index, ioctl_din, ram_dout;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait, pause_req, ram_rd;
    logic [10:0] ram_addr;

    ioctl_upload_reader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .pause_req(pause_req), .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
        .ram_dout(ram_dout), .ram_valid(ram_valid)
    );

    always #5 clk_sys = ~clk_sys;

    int n_pass = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM responder: each request answers lat cycles later with the byte stored at request time
    typedef struct { int due; logic [7:0] d; } rsp_t;
    rsp_t        rq[$];
    logic [7:0]  mem [0:2047];
    int          cyc = 0, lat = 3, rd_cnt = 0;
    logic        prev_rd = 1'b0, rd_long = 1'b0;
    logic [10:0] last_ra = '0;
    initial begin
        ram_valid = 1'b0;
        ram_dout = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            cyc++;
            ram_valid = 1'b0;
            if (ram_rd) begin
                rq.push_back('{cyc + lat, mem[ram_addr]});
                rd_cnt++;
                last_ra = ram_addr;
                if (prev_rd) rd_long = 1'b1;
            end
            prev_rd = ram_rd;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ram_valid = 1'b1;
                ram_dout = rq[0].d;
                void'(rq.pop_front());
            end
        end
    end

    // Scoreboard monitor: a strobe seen in READY completes when ioctl_wait is low again
    logic [7:0] exp_q[$];
    int         mon_n;
    initial forever begin
        @(negedge clk_sys);
        if (ioctl_rd && pause_req && !ioctl_wait) begin
            mon_n = 0;
            @(negedge clk_sys);
            while (ioctl_wait && mon_n < 600) begin
                mon_n++;
                @(negedge clk_sys);
            end
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("din", ioctl_din, exp_q.pop_front());
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time %0t, expected finish before 2ms", $time);
        $fatal(1);
    end

    logic [7:0] sum = 8'h00, din_model = 8'h00;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk_sys);
        while (ioctl_wait && n < 600) begin
            n++;
            @(negedge clk_sys);
        end
        chk("wait_release", ioctl_wait, 0);
        tick(1);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && rq.size() > 0; k++) tick(1);
        tick(2);
    endtask

    task automatic start_session(input int d);
        ioctl_index = 8'd2;
        ioctl_upload = 1'b1;
        tick(d);
        pause_ack = 1'b1;
        tick(2);
        sum = 8'h00;
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        pause_ack = 1'b0;
        tick(2);
    endtask

    // Reference: in range -> RAM byte after lat+2 wait cycles; beyond -> FF (or checksum) with no wait
    task automatic do_read(input logic [24:0] a, input int l);
        int n, c0;
        logic [7:0] e;
        bit inr;
        inr = a <= 25'h7FF;
        e = inr ? mem[a[10:0]] : (CKS && a == 25'h800) ? 8'h00 - sum : 8'hFF;
        lat = l;
        c0 = rd_cnt;
        exp_q.push_back(e);
        strobe(a);
        wait_done(n);
        chk("ram_rd_count", rd_cnt - c0, inr ? 1 : 0);
        chk("wait_cycles", n, inr ? l + 2 : 0);
        if (inr) begin
            chk("ram_addr", last_ra, a[10:0]);
            sum = sum + e;
        end
        din_model = e;
    endtask

    int n, c0, wcnt;
    logic [24:0] a;
    int r;
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        reset_n = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index = 8'd0;
        ioctl_rd = 1'b0;
        ioctl_addr = '0;
        pause_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_pause_req", pause_req, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_addr", ram_addr, 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        c0 = rd_cnt;
        strobe(25'h123);
        tick(2);
        @(negedge clk_sys);
        chk("idle_strobe_ram_rd", rd_cnt - c0, 0);
        chk("idle_strobe_din", ioctl_din, 8'h00);

        ioctl_index = 8'd3;
        ioctl_upload = 1'b1;
        tick(3);
        @(negedge clk_sys);
        chk("wrong_index_pause_req", pause_req, 0);

        ioctl_index = 8'd2;
        wcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (i == 10) pause_ack = 1'b1;
            @(negedge clk_sys);
            if (ioctl_wait) wcnt++;
        end
        chk("pause_wait_cycles", wcnt, 11);
        chk("pause_req_held", pause_req, 1);
        tick(1);
        sum = 8'h00;

        mem[11'h123] = 8'h5A;
        do_read(25'h123, 3);
        chk("din_5a", ioctl_din, 8'h5A);
        do_read(25'h900, 3);
        do_read(25'h1000800, 2);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            a = r < 7 ? 25'($urandom_range(0, 2047)) : r == 7 ? 25'h800 : 25'($urandom_range(2049, 33554431));
            do_read(a, $urandom_range(1, 8));
        end

        end_session();
        start_session(4);
        mem[11'h010] = 8'h01;
        mem[11'h011] = 8'h02;
        mem[11'h012] = 8'h03;
        do_read(25'h010, 2);
        do_read(25'h011, 5);
        do_read(25'h012, 1);
        do_read(25'h800, 1);
        chk("checksum_byte", ioctl_din, CKS ? 8'hFA : 8'hFF);

        mem[11'h040] = 8'h77;
        lat = 300;
        c0 = rd_cnt;
        exp_q.push_back(8'h00);
        strobe(25'h040);
        wait_done(n);
        chk("timeout_wait_cycles", n, 256);
        chk("timeout_ram_rd", rd_cnt - c0, 1);
        din_model = 8'h00;
        drain();
        @(negedge clk_sys);
        chk("late_valid_ignored", ioctl_din, 8'h00);
        tick(1);

        do_read(25'h011, 2);
        lat = 20;
        exp_q.push_back(din_model);
        strobe(25'h055);
        tick(4);
        ioctl_upload = 1'b0;
        wait_done(n);
        @(negedge clk_sys);
        chk("drop_pause_req", pause_req, 0);
        chk("drop_ram_rd", ram_rd, 0);
        drain();
        @(negedge clk_sys);
        chk("drop_din_kept", ioctl_din, din_model);
        pause_ack = 1'b0;
        tick(1);

        ioctl_upload = 1'b1;
        tick(3);
        c0 = rd_cnt;
        strobe(25'h010);
        tick(3);
        @(negedge clk_sys);
        chk("pause_strobe_ram_rd", rd_cnt - c0, 0);
        chk("pause_strobe_din", ioctl_din, din_model);
        chk("pause_wait", ioctl_wait, 1);
        tick(1);
        pause_ack = 1'b1;
        tick(2);
        sum = 8'h00;
        @(negedge clk_sys);
        chk("reack_wait", ioctl_wait, 0);
        tick(1);

        lat = 10;
        c0 = rd_cnt;
        exp_q.push_back(mem[11'h200]);
        strobe(25'h200);
        tick(2);
        pause_ack = 1'b0;
        tick(3);
        pause_ack = 1'b1;
        wait_done(n);
        chk("pauseloss_reissue", rd_cnt - c0, 2);
        chk("pauseloss_addr", last_ra, 11'h200);
        din_model = mem[11'h200];
        drain();

        ioctl_index = 8'd5;
        tick(1);
        @(negedge clk_sys);
        chk("index_change_pause_req", pause_req, 0);
        chk("index_change_wait", ioctl_wait, 0);
        ioctl_index = 8'd2;
        tick(3);
        do_read(25'h3FF, 4);
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pause_req", pause_req, 0);
        chk("async_rst_din", ioctl_din, 8'h00);

        chk("ram_rd_single_pulse", rd_long, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
